// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one word-aligned read at a time and
// returns the word from an internal array after a fixed latency, with a
// one-cycle valid pulse. A side load port writes the program into the array.
module imem_responder #(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instruction_req,
    input  logic [31:0] instruction_address,
    output logic        instruction_ready,
    output logic        instruction_valid,
    output logic [31:0] instruction_read_data,
    output logic        instruction_fault,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] lat_word;
    logic        lat_fault;

    logic [31:0] mem [DEPTH];

    logic [29:0] req_idx;
    logic        req_fault;
    logic [31:0] req_word;
    logic        accept;
    logic [29:0] load_idx;
    logic        load_ok;

    // Load byte-address low bits carry no meaning; the word index is all that matters.
    logic unused_load_bits;
    assign unused_load_bits = ^load_addr[1:0];

    // Request decode: misaligned or out-of-range addresses fault and never touch the array.
    assign req_idx   = instruction_address[31:2];
    assign req_fault = (instruction_address[1:0] != 2'b00) || (req_idx >= DEPTH_IDX);
    assign req_word  = req_fault ? NOP : mem[req_idx[AW-1:0]];

    assign instruction_ready = !rst && (state == S_IDLE || state == S_RESP);
    assign accept            = instruction_req && instruction_ready;

    assign load_idx = load_addr[31:2];
    assign load_ok  = load_en && (load_idx < DEPTH_IDX);

    // Program array write port; contents survive reset, and the read above sees
    // the pre-write value on a same-edge load/accept to the same word.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_idx[AW-1:0]] <= load_data;
        end
    end

    // Request FSM: latch the word at accept, count down the latency, pulse valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= S_IDLE;
            cnt                   <= 4'd0;
            lat_word              <= NOP;
            lat_fault             <= 1'b0;
            instruction_valid     <= 1'b0;
            instruction_fault     <= 1'b0;
            instruction_read_data <= NOP;
        end else begin
            instruction_valid <= 1'b0;
            instruction_fault <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (accept) begin
                        lat_word  <= req_word;
                        lat_fault <= req_fault;
                        if (LATENCY == 1) begin
                            state                 <= S_RESP;
                            instruction_valid     <= 1'b1;
                            instruction_read_data <= req_word;
                            instruction_fault     <= req_fault;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state                 <= S_RESP;
                        instruction_valid     <= 1'b1;
                        instruction_read_data <= lat_word;
                        instruction_fault     <= lat_fault;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder: three instances cover LATENCY=2
// (basic, faults, hazards), LATENCY=1 (back-to-back) and LATENCY=4 (abort).
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;

    // Instance A: LATENCY=2
    logic        rst_a, req_a, ready_a, valid_a, fault_a, load_en_a;
    logic [31:0] addr_a, data_a, load_addr_a, load_data_a;
    // Instance B: LATENCY=1
    logic        rst_b, req_b, ready_b, valid_b, fault_b, load_en_b;
    logic [31:0] addr_b, data_b, load_addr_b, load_data_b;
    // Instance C: LATENCY=4
    logic        rst_c, req_c, ready_c, valid_c, fault_c, load_en_c;
    logic [31:0] addr_c, data_c, load_addr_c, load_data_c;

    int checks   = 0;
    int failures = 0;

    imem_responder #(.DEPTH(1024), .LATENCY(2), .NOP(NOP)) u_a (
        .clk(clk), .rst(rst_a), .instruction_req(req_a), .instruction_address(addr_a),
        .instruction_ready(ready_a), .instruction_valid(valid_a),
        .instruction_read_data(data_a), .instruction_fault(fault_a),
        .load_en(load_en_a), .load_addr(load_addr_a), .load_data(load_data_a)
    );

    imem_responder #(.DEPTH(1024), .LATENCY(1), .NOP(NOP)) u_b (
        .clk(clk), .rst(rst_b), .instruction_req(req_b), .instruction_address(addr_b),
        .instruction_ready(ready_b), .instruction_valid(valid_b),
        .instruction_read_data(data_b), .instruction_fault(fault_b),
        .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b)
    );

    imem_responder #(.DEPTH(1024), .LATENCY(4), .NOP(NOP)) u_c (
        .clk(clk), .rst(rst_c), .instruction_req(req_c), .instruction_address(addr_c),
        .instruction_ready(ready_c), .instruction_valid(valid_c),
        .instruction_read_data(data_c), .instruction_fault(fault_c),
        .load_en(load_en_c), .load_addr(load_addr_c), .load_data(load_data_c)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write one word into instance A through the load port.
    task automatic load_a(input logic [31:0] a, input logic [31:0] d);
        load_en_a = 1'b1; load_addr_a = a; load_data_a = d;
        tick();
        load_en_a = 1'b0;
    endtask

    // Write one word into instance B through the load port.
    task automatic load_b(input logic [31:0] a, input logic [31:0] d);
        load_en_b = 1'b1; load_addr_b = a; load_data_b = d;
        tick();
        load_en_b = 1'b0;
    endtask

    // Reset held two cycles: idle outputs and ready low, then ready once released.
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        tick();
        checks++; if (valid_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid_a); end
        checks++; if (fault_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault got=%b exp=0", fault_a); end
        checks++; if (data_a !== NOP) begin failures++; $display("[TB] FAIL reset_data got=%h exp=%h", data_a, NOP); end
        checks++; if (ready_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_during got=%b exp=0", ready_a); end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();
        checks++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_after got=%b exp=1", ready_a); end
        checks++; if (ready_c !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_after_c got=%b exp=1", ready_c); end
    endtask

    // LATENCY=2 read of a loaded word: ready drops in WAIT, valid one cycle later.
    task automatic test_basic_read();
        load_a(32'h10, 32'h0050_0093);
        req_a = 1'b1; addr_a = 32'h10;
        tick();
        req_a = 1'b0;
        checks++; if (valid_a !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid got=%b exp=0", valid_a); end
        checks++; if (ready_a !== 1'b0) begin failures++; $display("[TB] FAIL basic_wait_ready got=%b exp=0", ready_a); end
        tick();
        checks++; if (valid_a !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid got=%b exp=1", valid_a); end
        checks++; if (data_a !== 32'h0050_0093) begin failures++; $display("[TB] FAIL basic_data got=%h exp=00500093", data_a); end
        checks++; if (fault_a !== 1'b0) begin failures++; $display("[TB] FAIL basic_fault got=%b exp=0", fault_a); end
        tick();
        checks++; if (valid_a !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse_end got=%b exp=0", valid_a); end
        checks++; if (data_a !== 32'h0050_0093) begin failures++; $display("[TB] FAIL basic_data_hold got=%h exp=00500093", data_a); end
    endtask

    // LATENCY=1 with req held: one response per cycle, in order, ready never drops.
    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0030_0193;
        for (int i = 0; i < 3; i++) load_b(32'(i * 4), words[i]);
        req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr_b = 32'(i * 4);
            checks++; if (ready_b !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready[%0d] got=%b exp=1", i, ready_b); end
            tick();
            checks++; if (valid_b !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d] got=%b exp=1", i, valid_b); end
            checks++; if (data_b !== words[i]) begin failures++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, data_b, words[i]); end
        end
        req_b = 1'b0;
        tick();
        checks++; if (valid_b !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_valid got=%b exp=0", valid_b); end
    endtask

    // Misaligned, past-the-end and last-word addresses; also an out-of-range load must not alias.
    task automatic test_faults();
        logic [31:0] addrs [4];
        logic [31:0] exp_d [4];
        logic        exp_f [4];
        load_a(32'hFFC, 32'hCAFE_F00D);
        load_a(32'h0,   32'h1234_5678);
        load_a(32'h1000, 32'hDEAD_BEEF);
        addrs[0] = 32'h6;    exp_d[0] = NOP;           exp_f[0] = 1'b1;
        addrs[1] = 32'h1000; exp_d[1] = NOP;           exp_f[1] = 1'b1;
        addrs[2] = 32'hFFC;  exp_d[2] = 32'hCAFE_F00D; exp_f[2] = 1'b0;
        addrs[3] = 32'h0;    exp_d[3] = 32'h1234_5678; exp_f[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_a = 1'b1; addr_a = addrs[i];
            tick();
            req_a = 1'b0;
            tick();
            checks++; if (valid_a !== 1'b1) begin failures++; $display("[TB] FAIL fault_valid[%0d] got=%b exp=1", i, valid_a); end
            checks++; if (data_a !== exp_d[i]) begin failures++; $display("[TB] FAIL fault_data[%0d] got=%h exp=%h", i, data_a, exp_d[i]); end
            checks++; if (fault_a !== exp_f[i]) begin failures++; $display("[TB] FAIL fault_flag[%0d] got=%b exp=%b", i, fault_a, exp_f[i]); end
            tick();
        end
    endtask

    // Same-edge load/accept reads the old word; a load during WAIT cannot change the reply.
    task automatic test_hazards();
        load_a(32'h8, 32'h1111_1111);
        req_a = 1'b1; addr_a = 32'h8;
        load_en_a = 1'b1; load_addr_a = 32'h8; load_data_a = 32'hAAAA_AAAA;
        tick();
        req_a = 1'b0; load_en_a = 1'b0;
        tick();
        checks++; if (data_a !== 32'h1111_1111 || valid_a !== 1'b1) begin failures++; $display("[TB] FAIL hazard_rbw got=%h/%b exp=11111111/1", data_a, valid_a); end
        tick();
        req_a = 1'b1; addr_a = 32'h8;
        tick();
        req_a = 1'b0;
        load_en_a = 1'b1; load_addr_a = 32'h8; load_data_a = 32'h5555_5555;
        tick();
        load_en_a = 1'b0;
        checks++; if (data_a !== 32'hAAAA_AAAA || valid_a !== 1'b1) begin failures++; $display("[TB] FAIL hazard_inflight got=%h/%b exp=aaaaaaaa/1", data_a, valid_a); end
        tick();
        req_a = 1'b1; addr_a = 32'h8;
        tick();
        req_a = 1'b0;
        tick();
        checks++; if (data_a !== 32'h5555_5555 || valid_a !== 1'b1) begin failures++; $display("[TB] FAIL hazard_later_load got=%h/%b exp=55555555/1", data_a, valid_a); end
        tick();
    endtask

    // LATENCY=4 request cut off by reset: ready returns, and no valid ever appears.
    task automatic test_abort();
        int seen;
        seen = 0;
        req_c = 1'b1; addr_c = 32'h0;
        tick();
        req_c = 1'b0;
        rst_c = 1'b1;
        tick();
        checks++; if (valid_c !== 1'b0) begin failures++; $display("[TB] FAIL abort_valid_in_rst got=%b exp=0", valid_c); end
        checks++; if (ready_c !== 1'b0) begin failures++; $display("[TB] FAIL abort_ready_in_rst got=%b exp=0", ready_c); end
        rst_c = 1'b0;
        #1;
        checks++; if (ready_c !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready_after got=%b exp=1", ready_c); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid_c !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL abort_no_valid got=%0d pulses exp=0", seen); end
        checks++; if (ready_c !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready_final got=%b exp=1", ready_c); end
    endtask

    // Scenario sequence and summary.
    initial begin
        req_a = 1'b0; addr_a = '0; load_en_a = 1'b0; load_addr_a = '0; load_data_a = '0;
        req_b = 1'b0; addr_b = '0; load_en_b = 1'b0; load_addr_b = '0; load_data_b = '0;
        req_c = 1'b0; addr_c = '0; load_en_c = 1'b0; load_addr_c = '0; load_data_c = '0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        test_reset();
        test_basic_read();
        test_back_to_back();
        test_faults();
        test_hazards();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
